// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, transmitter state encoding and the baud divisor helper.
package uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Clock cycles per bit, truncated.
    function automatic int calc_div(input int clk_freq_mhz, input int baud_rate);
        longint num;
        num = longint'(clk_freq_mhz) * 64'd1_000_000;
        return int'(num / longint'(baud_rate));
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 while running and pulses bit_end_o on the last cycle of each bit.
// Restart re-aligns the count to the start of a frame; no backpressure, purely a timing source.
module uart_baud_gen #(
    parameter int DIV = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    input  logic run_i,
    output logic bit_end_o
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q = '0;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || !run_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = run_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter, LSB first; first start-bit cycle follows accept, frame lasts 10*DIV cycles.
// wready_o is low for the whole frame; offers made while busy are dropped, not buffered.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int BAUD_RATE    = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       txd_o,
    input  logic       wvalid_i,
    output logic       wready_o,
    input  logic [7:0] wdata_i
);

    localparam int DIV = calc_div(CLK_FREQ_MHZ, BAUD_RATE);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_core: clock cycles per bit must be at least 2");
    end

    uart_state_t          state_q = IDLE;
    uart_state_t          state_d;
    logic [DATA_BITS-1:0] shift_q = '0;
    logic [DATA_BITS-1:0] shift_d;
    logic [2:0]           bit_idx_q = '0;
    logic [2:0]           bit_idx_d;
    logic                 txd_q = 1'b1;
    logic                 txd_d;

    logic accept;
    logic bit_end;

    assign wready_o = (state_q == IDLE);
    assign accept   = wvalid_i && wready_o;
    assign txd_o    = txd_q;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (accept),
        .run_i     (state_q != IDLE),
        .bit_end_o (bit_end)
    );

    // txd_d carries the level of the bit that begins on the next cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    state_d   = START;
                    shift_d   = wdata_i;
                    bit_idx_d = '0;
                    txd_d     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core at DIV=100: directed steps, waveform checks and a bit-centre receiver scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txd;
    logic       wvalid = 1'b0;
    logic       wready;
    logic [7:0] wdata = 8'h00;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rst_cnt  = 0;
    int rx_cnt   = 0;
    logic [7:0] exp_q[$];

    uart_tx_core #(
        .CLK_FREQ_MHZ (100),
        .BAUD_RATE    (1_000_000)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .txd_o    (txd),
        .wvalid_i (wvalid),
        .wready_o (wready),
        .wdata_i  (wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_cnt <= rst_cnt + 1;
    end

    initial begin : watchdog
        #800us;
        $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    // Waits (bounded) for an idle transmitter, then offers b; the accept edge ends cycle acc_cyc.
    task automatic offer(input logic [7:0] b, output int acc_cyc);
        int n = 0;
        @(negedge clk);
        while (wready !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("offer_ready", wready, 1'b1);
        wvalid  = 1'b1;
        wdata   = b;
        acc_cyc = cyc;
        if (wready === 1'b1) exp_q.push_back(b);
    endtask

    // Checks every cycle of the frame started by the preceding offer; also scrambles wdata_i after accept.
    task automatic watch_frame(input logic [7:0] b, input string tag);
        int bad_txd = 0;
        int bad_rdy = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wvalid = 1'b0;
                wdata  = ~b;
            end
            if (txd !== frame_bit(b, (c - 1) / 100)) bad_txd++;
            if (wready !== 1'b0) bad_rdy++;
        end
        check({tag, "_txd_bad_cycles"}, bad_txd, 0);
        check({tag, "_busy_bad_cycles"}, bad_rdy, 0);
        @(negedge clk);
        check({tag, "_ready_back"}, wready, 1'b1);
        check({tag, "_idle_high"}, txd, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (wready !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_reached"}, wready, 1'b1);
        repeat (5) @(negedge clk);
    endtask

    // Bit-centre receiver: samples 50+100k cycles after the first start-bit cycle.
    initial begin : rx
        logic       prev;
        logic       st;
        logic       sp;
        logic [7:0] b;
        int         r0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && txd === 1'b0 && rst === 1'b0) begin
                r0 = rst_cnt;
                repeat (50) @(negedge clk);
                st = txd;
                for (int k = 0; k < 8; k++) begin
                    repeat (100) @(negedge clk);
                    b[k] = txd;
                end
                repeat (100) @(negedge clk);
                sp = txd;
                if (rst_cnt != r0) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    check("rx_start_bit", st, 1'b0);
                    check("rx_stop_bit", sp, 1'b1);
                    check("rx_expected_pending", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) check("rx_byte", b, exp_q.pop_front());
                    rx_cnt++;
                end
            end
            prev = txd;
        end
    end

    initial begin : stim
        int t;
        int a1;
        int a2;
        int n;
        int bad_txd;
        int bad_rdy;

        // Reset and long idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_wready", wready, 1'b1);
        rst = 1'b0;
        bad_txd = 0;
        bad_rdy = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad_txd++;
            if (wready !== 1'b1) bad_rdy++;
        end
        check("idle_txd_bad_cycles", bad_txd, 0);
        check("idle_wready_bad_cycles", bad_rdy, 0);

        // Single bytes with full waveform check
        offer(8'h55, t);
        watch_frame(8'h55, "byte55");
        offer(8'hA3, t);
        watch_frame(8'hA3, "byteA3");

        // Busy drop: wvalid held high through the frame
        offer(8'h01, a1);
        @(negedge clk);
        wdata = 8'hFF;
        n = 0;
        while (wready !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("busy_ready_returned", wready, 1'b1);
        a2 = cyc;
        if (wready === 1'b1) exp_q.push_back(8'hFF);
        check("busy_accept_spacing", a2 - a1, 1001);
        @(negedge clk);
        wvalid = 1'b0;
        check("busy_second_accepted", wready, 1'b0);
        @(negedge clk);
        wait_idle("busy");

        // Reset during data bit 3
        offer(8'h3C, t);
        @(negedge clk);
        wvalid = 1'b0;
        repeat (449) @(negedge clk);
        check("midframe_bit3", txd, 1'b1);
        check("midframe_busy", wready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_txd", txd, 1'b1);
        check("abort_wready", wready, 1'b1);
        repeat (600) @(negedge clk);
        offer(8'h96, t);
        watch_frame(8'h96, "after_abort");

        // Reset coincident with an offer: byte must not be accepted
        @(negedge clk);
        rst    = 1'b1;
        wvalid = 1'b1;
        wdata  = 8'h77;
        @(negedge clk);
        rst    = 1'b0;
        wvalid = 1'b0;
        check("rst_wins_wready", wready, 1'b1);
        bad_txd = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad_txd++;
        end
        check("rst_wins_no_frame", bad_txd, 0);

        // Stream of 16 bytes with single-cycle offers
        for (int i = 0; i < 16; i++) begin
            offer(8'(i), t);
            @(negedge clk);
            wvalid = 1'b0;
        end
        @(negedge clk);
        wait_idle("stream");
        repeat (20) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        check("rx_frame_count", rx_cnt, 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
